// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame size, device-transmit FSM states, parity helper.
// Reused by the device transmitter, the receiver and the future host-side transmitter.
package ps2_pkg;

    localparam int PS2_FRAME_BITS = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_GAP  = 2'd3
    } ps2_tx_state_t;

    function automatic logic ps2_odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_tick_gen.sv
// Loadable down-counter; done pulses for one cycle when the loaded count expires.
// A load of N-1 makes done fire on the N-th cycle after the load edge.
module ps2_tick_gen #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;
    logic         active;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (load) begin
            cnt    <= load_val;
            active <= 1'b1;
        end else if (active) begin
            if (cnt == '0) active <= 1'b0;
            else           cnt    <= cnt - W'(1);
        end
    end

    assign done = active && (cnt == '0);

endmodule

// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 transmitter: byte in, 11-bit frame out on kbd = {data, clock}.
// Optional PS2_KBD_TX_ERR_INJECT_EN adds err_inject to invert the parity of one frame.
module ps2_kbd_tx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV = 2500,
    parameter int GAP     = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [1:0] kbd,
`ifdef PS2_KBD_TX_ERR_INJECT_EN
    input  logic       err_inject,
`endif
    output logic       busy
);

    localparam int MAXC = (CLK_DIV > GAP) ? CLK_DIV : GAP;
    localparam int CW   = $clog2(MAXC);
    localparam logic [CW-1:0] DIV_LD = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LD = CW'(GAP - 1);
    localparam logic [3:0]    LAST   = 4'(PS2_FRAME_BITS - 1);

    ps2_tx_state_t               state, state_nxt;
    logic [PS2_FRAME_BITS-1:0]   frame;
    logic [3:0]                  idx;
    logic                        accept, tick, ld, par;
    logic [CW-1:0]               ld_val;

    assign accept = in_valid && in_ready && (state == ST_IDLE);

`ifdef PS2_KBD_TX_ERR_INJECT_EN
    assign par = ps2_odd_parity(in_data) ^ err_inject;
`else
    assign par = ps2_odd_parity(in_data);
`endif

    ps2_tick_gen #(.W(CW)) u_tick (
        .clk      (clk),
        .rst      (rst),
        .load     (ld),
        .load_val (ld_val),
        .done     (tick)
    );

    always_comb begin
        state_nxt = state;
        ld        = 1'b0;
        ld_val    = DIV_LD;
        case (state)
            ST_IDLE: if (accept) begin state_nxt = ST_HIGH; ld = 1'b1; end
            ST_HIGH: if (tick)   begin state_nxt = ST_LOW;  ld = 1'b1; end
            ST_LOW: if (tick) begin
                ld = 1'b1;
                if (idx == LAST) begin
                    state_nxt = ST_GAP;
                    ld_val    = GAP_LD;
                end else begin
                    state_nxt = ST_HIGH;
                end
            end
            ST_GAP:  if (tick)   state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // frame[0] is always the bit on the wire; shifting happens only at HIGH entry
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            frame    <= '1;
            idx      <= '0;
            kbd      <= 2'b11;
            in_ready <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt == ST_IDLE);
            busy     <= (state_nxt != ST_IDLE);
            case (state)
                ST_IDLE: if (accept) begin
                    frame <= {1'b1, par, in_data, 1'b0};
                    idx   <= '0;
                    kbd   <= 2'b01;
                end
                ST_HIGH: if (tick) kbd[0] <= 1'b0;
                ST_LOW: if (tick) begin
                    if (idx == LAST) begin
                        kbd <= 2'b11;
                    end else begin
                        idx   <= idx + 4'd1;
                        frame <= frame >> 1;
                        kbd   <= {frame[1], 1'b1};
                    end
                end
                default: kbd <= 2'b11;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Scoreboard bench for ps2_kbd_tx with CLK_DIV=4, GAP=8; frames are captured on kbd[0] falling edges.
// Define PS2_KBD_TX_ERR_INJECT_EN to also exercise parity error injection.
module tb_ps2_kbd_tx;

    localparam int CLK_DIV = 4;
    localparam int GAP     = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, busy;
    logic [1:0] kbd;
`ifdef PS2_KBD_TX_ERR_INJECT_EN
    logic       err_inject = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    logic [10:0] exp_q[$];
    logic [10:0] got_mem[0:63];
    int          got_wr = 0;
    int          got_rd = 0;
    logic        glitch = 1'b0;

    always #5 clk = ~clk;

    ps2_kbd_tx #(.CLK_DIV(CLK_DIV), .GAP(GAP)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .kbd        (kbd),
`ifdef PS2_KBD_TX_ERR_INJECT_EN
        .err_inject (err_inject),
`endif
        .busy       (busy)
    );

    // Receiver model: sample data on each falling edge of the PS/2 clock
    logic [10:0] sh = '0;
    int          nbits = 0;
    logic        prev_c = 1'b1;
    logic        low_d = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            nbits  = 0;
            prev_c = 1'b1;
        end else begin
            if (prev_c && !kbd[0]) begin
                sh[nbits] = kbd[1];
                low_d     = kbd[1];
                nbits++;
                if (nbits == 11) begin
                    got_mem[got_wr % 64] = sh;
                    got_wr++;
                    nbits = 0;
                end
            end else if (!kbd[0] && kbd[1] !== low_d) begin
                glitch = 1'b1;
            end
            prev_c = kbd[0];
        end
    end

    function automatic logic [10:0] mk(input logic [7:0] d, input logic inj);
        return {1'b1, (~^d) ^ inj, d, 1'b0};
    endfunction

    // Call on a negedge; returns on the negedge whose in_ready=1 makes the next posedge accept.
    task automatic send_byte(input logic [7:0] d, input logic inj, input logic push);
        int n;
        n = 0;
        in_data  = d;
        in_valid = 1'b1;
`ifdef PS2_KBD_TX_ERR_INJECT_EN
        err_inject = inj;
`endif
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!in_ready) begin
            bad++;
            $display("FAIL send_%h: in_ready=%b after %0d cycles, required 1", d, in_ready, n);
        end
        if (push) exp_q.push_back(mk(d, inj));
    endtask

    task automatic check_frame(input string name, output logic [10:0] got);
        int n;
        logic [10:0] e;
        n = 0;
        while (got_rd >= got_wr && n < 2000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (got_rd >= got_wr) begin
            bad++;
            got = 'x;
            $display("FAIL %s: no frame captured within %0d cycles", name, n);
        end else begin
            got = got_mem[got_rd % 64];
            got_rd++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 11'bx;
            if (got !== e) begin
                bad++;
                $display("FAIL %s: frame=%b required=%b", name, got, e);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (kbd !== 2'b11 || busy !== 1'b0 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold: kbd=%b busy=%b in_ready=%b required 11/0/0", kbd, busy, in_ready);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || kbd !== 2'b11 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: in_ready=%b kbd=%b busy=%b required 1/11/0", in_ready, kbd, busy);
        end
    endtask

    task automatic test_single();
        logic [10:0] g;
        int cyc;
        send_byte(8'h1C, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (kbd !== 2'b01 || in_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL start_bit: kbd=%b in_ready=%b busy=%b required 01/0/1", kbd, in_ready, busy);
        end
        cyc = 1;
        while (!in_ready && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (cyc != 97) begin
            bad++;
            $display("FAIL ready_return: %0d cycles, required 97", cyc);
        end
        check_frame("single_1c", g);
        total++;
        if (g !== 11'b1_0_00011100_0) begin
            bad++;
            $display("FAIL single_1c_bits: frame=%b required=%b", g, 11'b1_0_00011100_0);
        end
    endtask

    task automatic test_parity();
        logic [7:0]  d[3];
        logic        p[3];
        logic [10:0] g;
        d = '{8'h00, 8'hFF, 8'h01};
        p = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            send_byte(d[i], 1'b0, 1'b1);
            @(negedge clk);
            in_valid = 1'b0;
            check_frame("parity_frame", g);
            total++;
            if (g[9] !== p[i] || g[8:1] !== d[i]) begin
                bad++;
                $display("FAIL parity_%h: parity=%b data=%h required %b/%h", d[i], g[9], g[8:1], p[i], d[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc, run, start2, acc_cyc;
        logic acc;
        logic [10:0] g;
        send_byte(8'hF0, 1'b0, 1'b1);
        @(negedge clk);
        in_data = 8'h1C;
        cyc = 1; run = 0; start2 = 0; acc = 1'b0; acc_cyc = 0;
        while (start2 == 0 && cyc < 400) begin
            if (in_ready && !acc) begin
                acc = 1'b1;
                acc_cyc = cyc;
                exp_q.push_back(mk(8'h1C, 1'b0));
            end
            if (kbd == 2'b11) run++;
            else if (kbd == 2'b01 && acc) start2 = cyc;
            else run = 0;
            if (start2 == 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        in_valid = 1'b0;
        total++;
        if (acc_cyc != 97) begin
            bad++;
            $display("FAIL b2b_accept: second accept at cycle %0d, required 97", acc_cyc);
        end
        total++;
        if (run != GAP + 1 || start2 != 98) begin
            bad++;
            $display("FAIL b2b_gap: idle=%0d start=%0d required %0d/98", run, start2, GAP + 1);
        end
        check_frame("b2b_f0", g);
        check_frame("b2b_1c", g);
    endtask

    task automatic test_reset_mid();
        logic [10:0] g;
        send_byte(8'hAA, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (37) @(negedge clk);   // cycle 38: bit 4, clock low
        total++;
        if (kbd !== 2'b10) begin
            bad++;
            $display("FAIL mid_bit4: kbd=%b required 10", kbd);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (kbd !== 2'b11 || busy !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: kbd=%b busy=%b in_ready=%b required 11/0/0", kbd, busy, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_byte(8'h55, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check_frame("after_reset_55", g);
    endtask

`ifdef PS2_KBD_TX_ERR_INJECT_EN
    task automatic test_err_inject();
        logic [10:0] g;
        send_byte(8'h1C, 1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        err_inject = 1'b0;
        check_frame("inject_1c", g);
        total++;
        if (g !== 11'b1_1_00011100_0) begin
            bad++;
            $display("FAIL inject_bits: frame=%b required=%b", g, 11'b1_1_00011100_0);
        end
        send_byte(8'h1C, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check_frame("inject_clear", g);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_parity();
        test_back_to_back();
        test_reset_mid();
`ifdef PS2_KBD_TX_ERR_INJECT_EN
        test_err_inject();
`endif
        total++;
        if (glitch !== 1'b0) begin
            bad++;
            $display("FAIL data_stable: data moved while clock low=%b required 0", glitch);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
